// File: rtl/tdc_phase_decoder_if.sv
// Handshake/data bundle between the ADPLL loop side and tdc_phase_decoder.
// master drives measurement requests and TDC results; slave is the decoder.
interface tdc_phase_decoder_if;
  logic       start_meas;
  logic       select_in;
  logic       fine_done_pre;
  logic       early;
  logic [4:0] counter_rise;
  logic [4:0] counter_fall;
  logic [7:0] trip_b;
  logic       enable_PFD_TDC;
  logic       select_PFD_input;
  logic [9:0] phase_err;
  logic       phase_err_valid;
  logic       busy;
  logic       timeout;
  logic       bubble_err;

  modport master (
    output start_meas, select_in, fine_done_pre, early,
           counter_rise, counter_fall, trip_b,
    input  enable_PFD_TDC, select_PFD_input, phase_err,
           phase_err_valid, busy, timeout, bubble_err
  );

  modport slave (
    input  start_meas, select_in, fine_done_pre, early,
           counter_rise, counter_fall, trip_b,
    output enable_PFD_TDC, select_PFD_input, phase_err,
           phase_err_valid, busy, timeout, bubble_err
  );
endinterface

// File: rtl/tdc_phase_decoder.sv
// PFD/TDC reader: arms one measurement per request and decodes coarse+fine into a signed phase error.
// Define TDC_DECODE_AVG_EN to output a 4-sample moving average instead of the raw decode.
module tdc_phase_decoder #(
  parameter int unsigned TIMEOUT_CYC = 15,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               ref_clk,
  input  logic               reset,
  tdc_phase_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_CAPTURE,
    ST_DECODE,
    ST_COOL
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  state_t                 state;
  logic [7:0]             wait_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   done_prev;
  logic                   done_rise;

  logic                   cap_early;
  logic [4:0]             cap_rise;
  logic [4:0]             cap_fall;
  logic [7:0]             cap_trip;

  logic [3:0]             fine;
  logic [5:0]             coarse;
  logic [8:0]             mag;
  logic [9:0]             raw_err;
  logic [7:0]             trip_low;
  logic                   trip_legal;

`ifdef TDC_DECODE_AVG_EN
  logic [2:0][9:0]        hist;
  logic [1:0]             n_samp;
  logic [11:0]            avg_sum;
`endif

  // The edge detector runs in every state so a rise outside WAIT is consumed, not deferred.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      sync_q    <= '0;
      done_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.fine_done_pre};
      done_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    done_rise = sync_q[SYNC_STAGES-1] & ~done_prev;
    fine      = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      fine = fine + {3'b000, ~cap_trip[i]};
    end
    coarse     = {1'b0, cap_rise} + {1'b0, cap_fall};
    mag        = {coarse, 3'b000} + {5'b00000, fine};
    raw_err    = cap_early ? {1'b0, mag} : (~{1'b0, mag} + 10'd1);
    // Legal code: zeros contiguous from bit 0, so the inverted code is a low-aligned run of ones.
    trip_low   = ~cap_trip;
    trip_legal = ((trip_low & (trip_low + 8'd1)) == 8'd0);
  end

`ifdef TDC_DECODE_AVG_EN
  always_comb begin
    avg_sum = {{2{raw_err[9]}}, raw_err}
            + {{2{hist[0][9]}}, hist[0]}
            + {{2{hist[1][9]}}, hist[1]}
            + {{2{hist[2][9]}}, hist[2]};
  end
`endif

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state                <= ST_IDLE;
      wait_cnt             <= '0;
      cap_early            <= 1'b0;
      cap_rise             <= '0;
      cap_fall             <= '0;
      cap_trip             <= '1;
      bus.enable_PFD_TDC   <= 1'b0;
      bus.select_PFD_input <= 1'b0;
      bus.phase_err        <= '0;
      bus.phase_err_valid  <= 1'b0;
      bus.busy             <= 1'b0;
      bus.timeout          <= 1'b0;
      bus.bubble_err       <= 1'b0;
`ifdef TDC_DECODE_AVG_EN
      hist                 <= '0;
      n_samp               <= '0;
`endif
    end else begin
      bus.phase_err_valid <= 1'b0;
      bus.timeout         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start_meas) begin
            bus.select_PFD_input <= bus.select_in;
            bus.busy             <= 1'b1;
            state                <= ST_ARM;
          end
        end
        ST_ARM: begin
          bus.enable_PFD_TDC <= 1'b1;
          wait_cnt           <= '0;
          state              <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_rise) begin
            state <= ST_CAPTURE;
          end else if (wait_cnt == TIMEOUT_LIM) begin
            bus.timeout        <= 1'b1;
            bus.enable_PFD_TDC <= 1'b0;
            state              <= ST_COOL;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_CAPTURE: begin
          cap_early <= bus.early;
          cap_rise  <= bus.counter_rise;
          cap_fall  <= bus.counter_fall;
          cap_trip  <= bus.trip_b;
          state     <= ST_DECODE;
        end
        ST_DECODE: begin
          bus.enable_PFD_TDC <= 1'b0;
          if (!trip_legal) begin
            bus.bubble_err <= 1'b1;
          end
`ifdef TDC_DECODE_AVG_EN
          hist <= {hist[1:0], raw_err};
          if (n_samp == 2'd3) begin
            bus.phase_err       <= avg_sum[11:2];
            bus.phase_err_valid <= 1'b1;
          end else begin
            n_samp <= n_samp + 2'd1;
          end
`else
          bus.phase_err       <= raw_err;
          bus.phase_err_valid <= 1'b1;
`endif
          state <= ST_COOL;
        end
        ST_COOL: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_phase_decoder.sv
// Randomised scoreboard bench for tdc_phase_decoder: stimulus pushes expected strobes, a monitor pops them.
// Works in both builds; TDC_DECODE_AVG_EN switches the reference model to the moving average.
module tb_tdc_phase_decoder;

  logic   clk = 1'b0;
  logic   reset;
  int     total = 0;
  int     bad = 0;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tdc_phase_decoder_if bus ();

  tdc_phase_decoder #(
    .TIMEOUT_CYC (15),
    .SYNC_STAGES (2)
  ) dut (
    .ref_clk (clk),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct {
    logic [9:0] val;
    longint     when;
  } exp_t;

  exp_t sb[$];
  int   hist[$];
  bit   exp_bubble = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference decode straight from the arithmetic rules.
  function automatic int ref_decode(input bit e, input logic [4:0] r, input logic [4:0] f,
                                    input logic [7:0] t);
    int mag;
    mag = (int'(r) + int'(f)) * 8 + (8 - $countones(t));
    return e ? mag : -mag;
  endfunction

  function automatic bit is_thermo(input logic [7:0] t);
    logic [7:0] m;
    for (int k = 0; k <= 8; k++) begin
      m = 8'hFF;
      m = m << k;
      if (t == m) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_push(input int v, input longint when);
    exp_t e;
`ifdef TDC_DECODE_AVG_EN
    int s;
    int a;
    hist.push_back(v);
    if (hist.size() > 4) void'(hist.pop_front());
    if (hist.size() == 4) begin
      s = 0;
      foreach (hist[i]) s += hist[i];
      a = s >>> 2;
      e.val  = a[9:0];
      e.when = when;
      sb.push_back(e);
    end
`else
    e.val  = v[9:0];
    e.when = when;
    sb.push_back(e);
`endif
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.phase_err_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got phase_err=%0h want no strobe (cycle %0d)", bus.phase_err, cyc);
      end else begin
        e = sb.pop_front();
        chk("phase_err", bus.phase_err, e.val);
        chk("valid_cycle", cyc[31:0], e.when[31:0]);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL idle_wait: got busy=%b want 0 within 60 cycles", bus.busy);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_enable"},    bus.enable_PFD_TDC, 0);
    chk({tag, "_select"},    bus.select_PFD_input, 0);
    chk({tag, "_phase_err"}, bus.phase_err, 0);
    chk({tag, "_valid"},     bus.phase_err_valid, 0);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_timeout"},   bus.timeout, 0);
    chk({tag, "_bubble"},    bus.bubble_err, 0);
  endtask

  task automatic measure(input bit e, input logic [4:0] r, input logic [4:0] f,
                         input logic [7:0] t, input bit sel, input bit poke);
    longint c;
    int     d;
    wait_idle();
    @(negedge clk);
    bus.early        = e;
    bus.counter_rise = r;
    bus.counter_fall = f;
    bus.trip_b       = t;
    bus.select_in    = sel;
    bus.start_meas   = 1'b1;
    @(negedge clk);
    bus.start_meas = 1'b0;
    bus.select_in  = ~sel;
    chk("select_latch", bus.select_PFD_input, sel);
    chk("busy_armed", bus.busy, 1);
    @(negedge clk);
    chk("enable_on", bus.enable_PFD_TDC, 1);
    d = $urandom_range(0, 5);
    repeat (d) @(negedge clk);
    if (poke) begin
      bus.start_meas = 1'b1;
      @(negedge clk);
      bus.start_meas = 1'b0;
    end
    bus.fine_done_pre = 1'b1;
    c = cyc;
    model_push(ref_decode(e, r, f, t), c + 5);
    if (!is_thermo(t)) exp_bubble = 1'b1;
    if (poke) begin
      repeat (4) @(negedge clk);
      bus.start_meas = 1'b1;
      @(negedge clk);
      bus.start_meas = 1'b0;
    end
    wait_idle();
    chk("bubble_err", bus.bubble_err, exp_bubble);
    chk("enable_off", bus.enable_PFD_TDC, 0);
    bus.fine_done_pre = 1'b0;
    repeat (3) @(negedge clk);
    if (poke) chk("busy_after_ignored_start", bus.busy, 0);
  endtask

  task automatic timeout_test();
    longint k;
    longint seen = -1;
    logic   en_at = 1'bx;
    logic   prev_en = 1'b0;
    wait_idle();
    @(negedge clk);
    bus.select_in  = 1'b1;
    bus.start_meas = 1'b1;
    k = cyc;
    @(negedge clk);
    bus.start_meas = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.timeout === 1'b1) begin
        seen  = cyc;
        en_at = bus.enable_PFD_TDC;
        break;
      end
      prev_en = bus.enable_PFD_TDC;
      @(negedge clk);
    end
    chk("timeout_cycle", seen[31:0], 32'(k + 18));
    chk("timeout_enable_low", en_at, 0);
    chk("enable_before_timeout", prev_en, 1);
    @(negedge clk);
    chk("timeout_pulse_width", bus.timeout, 0);
    chk("cool_to_idle_busy", bus.busy, 0);
    chk("cool_enable_low", bus.enable_PFD_TDC, 0);
  endtask

  task automatic reset_mid_wait();
    wait_idle();
    @(negedge clk);
    bus.select_in  = 1'b1;
    bus.start_meas = 1'b1;
    @(negedge clk);
    bus.start_meas = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_enable", bus.enable_PFD_TDC, 1);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset      = 1'b0;
    exp_bubble = 1'b0;
    hist.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t;
    logic [7:0] m;
    reset             = 1'b1;
    bus.start_meas    = 1'b0;
    bus.select_in     = 1'b0;
    bus.fine_done_pre = 1'b0;
    bus.early         = 1'b0;
    bus.counter_rise  = '0;
    bus.counter_fall  = '0;
    bus.trip_b        = '1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    measure(1'b1, 5'd3,  5'd2,  8'b1111_1000, 1'b1, 1'b0);
    measure(1'b0, 5'd3,  5'd2,  8'b1111_1000, 1'b0, 1'b0);
    measure(1'b1, 5'd31, 5'd31, 8'h00,        1'b1, 1'b0);
    measure(1'b1, 5'd3,  5'd2,  8'b1110_1000, 1'b0, 1'b0);
    measure(1'b0, 5'd1,  5'd1,  8'hFF,        1'b1, 1'b1);

    timeout_test();
    reset_mid_wait();

    for (int i = 0; i < 4; i++) measure(1'b1, 5'd3, 5'd2, 8'b1111_1000, 1'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) measure(1'b0, 5'd3, 5'd2, 8'b1111_1000, 1'($urandom), 1'b0);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        m = 8'hFF;
        t = m << $urandom_range(0, 8);
      end else begin
        t = 8'($urandom);
      end
      measure(1'($urandom), 5'($urandom), 5'($urandom), t, 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d strobes outstanding want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
